rvx_memory_copy_engine: RTL and testbench
=========================================

RVX_MEMORY_COPY_ENGINE -- requirements
Module: rvx_memory_copy_engine

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 The block SHALL have exactly one clock and a synchronous, active-low reset (reset_n), with ports as follows:
- clock  input  1  sole clock, all state updates on rising edge
- reset_n  input  1  synchronous active-low reset
- start  input  1  one-cycle copy request, sampled only in IDLE
- source_address  input  32  byte address of first source word
- destination_address  input  32  byte address of first destination word
- word_count  input  16  number of 32-bit words to copy
- busy  output  1  high while a copy is in progress
- done  output  1  one-cycle pulse when a copy completes
- words_copied  output  16  count of words written in current/last copy
- m_address  output  32  manager-port address
- m_rdata  input  32  read data, valid when m_rresponse high
- m_rrequest  output  1  read request pulse
- m_rresponse  input  1  read completion
- m_wdata  output  32  write data
- m_wstrobe  output  4  byte enables
- m_wrequest  output  1  write request pulse
- m_wresponse  input  1  write completion

Function
REQ-003 The block SHALL act as the initiator of the memory port request/response protocol, copying word_count aligned words from source to destination, one word in flight at a time.
REQ-004 FSM states SHALL be IDLE, READ_REQ, READ_WAIT, WRITE_REQ, WRITE_WAIT, DONE.
REQ-005 In IDLE with start=1: latch source_address and destination_address with bits [1:0] forced to 0, latch word_count, clear words_copied; go to DONE if word_count=0, else READ_REQ.
REQ-006 READ_REQ: m_rrequest=1 for exactly one cycle, m_address=current source; then READ_WAIT unconditionally.
REQ-007 READ_WAIT: m_address held; on m_rresponse=1, capture m_rdata into the data register and go to WRITE_REQ; otherwise wait indefinitely.
REQ-008 WRITE_REQ: m_wrequest=1 for exactly one cycle, m_address=current destination, m_wdata=data register, m_wstrobe=4'hF; then WRITE_WAIT.
REQ-009 WRITE_WAIT: m_address/m_wdata held; on m_wresponse=1, increment words_copied and both addresses by 4 (modulo 2^32, wrap silently), then go to DONE if words_copied+1 equals the latched count, else READ_REQ.
REQ-010 DONE: done=1 for one cycle; then IDLE.
REQ-011 m_wstrobe SHALL be 4'h0 whenever m_wrequest=0; m_wdata is don't-care outside WRITE_REQ/WRITE_WAIT.
REQ-012 m_rresponse/m_wresponse SHALL be ignored in any state other than READ_WAIT/WRITE_WAIT respectively.
REQ-013 busy SHALL be 1 in READ_REQ, READ_WAIT, WRITE_REQ and WRITE_WAIT, and 0 in IDLE and DONE; start SHALL be ignored outside IDLE, including in DONE.
REQ-014 With a 1-cycle-latency responder, throughput SHALL be 4 cycles per word; done SHALL assert 4N+1 cycles after the edge that samples start (N>0), or 1 cycle after for N=0.
REQ-015 Source/destination overlap SHALL NOT be detected; the copy proceeds ascending, word by word.

Reset
REQ-016 With reset_n=0 at a rising edge: state=IDLE, busy=0, done=0, m_rrequest=0, m_wrequest=0, m_wstrobe=0, m_address=0, words_copied=0, data register=0.
REQ-017 Reset mid-copy SHALL abort immediately with no further requests; responses arriving after reset SHALL be ignored per REQ-012.

Verification
REQ-018 Bench pairs the block with the tightly coupled memory (1-cycle response) and covers:
- Preload words 0x100..0x10C = A0,A1,A2,A3; start src=0x100, dst=0x200, count=4 -> 0x200..0x20C match, done 17 cycles after start, words_copied=4.
- count=0 -> done pulses next cycle, no m_rrequest/m_wrequest ever asserted.
- src=0x103, dst=0x202, count=1 -> reads 0x100, writes 0x200.
- Responder delays every response 3 extra cycles -> data correct, m_address stable throughout each wait, one request pulse per access.
- reset_n=0 in cycle 6 of a 4-word copy -> outputs at REQ-016 values next cycle, no further writes, later start works normally.
- start held high across a whole copy -> exactly one copy, busy never re-asserts until after DONE→IDLE.

Source files
------------

// File: rtl/rvx_memory_copy_engine_if.sv
// Manager-side memory port of the copy engine: one request/response pair per
// direction, sharing a single address bus.
interface rvx_memory_copy_engine_if;
    logic [31:0] m_address;
    logic [31:0] m_rdata;
    logic        m_rrequest;
    logic        m_rresponse;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrobe;
    logic        m_wrequest;
    logic        m_wresponse;

    modport master (
        output m_address, m_rrequest, m_wdata, m_wstrobe, m_wrequest,
        input  m_rdata, m_rresponse, m_wresponse
    );

    modport slave (
        input  m_address, m_rrequest, m_wdata, m_wstrobe, m_wrequest,
        output m_rdata, m_rresponse, m_wresponse
    );
endinterface

// File: rtl/rvx_memory_copy_engine.sv
// Word-by-word memory copy engine: reads one aligned word, writes it back out,
// and repeats with a single access in flight at any time.
module rvx_memory_copy_engine (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] source_address,
    input  logic [31:0] destination_address,
    input  logic [15:0] word_count,
    output logic        busy,
    output logic        done,
    output logic [15:0] words_copied,
    rvx_memory_copy_engine_if.master m_port
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] READ_REQ   = 3'd1;
    localparam logic [2:0] READ_WAIT  = 3'd2;
    localparam logic [2:0] WRITE_REQ  = 3'd3;
    localparam logic [2:0] WRITE_WAIT = 3'd4;
    localparam logic [2:0] DONE       = 3'd5;

    logic [2:0]  state_q,  state_d;
    logic [31:0] src_q,    src_d;
    logic [31:0] dst_q,    dst_d;
    logic [15:0] count_q,  count_d;
    logic [15:0] copied_q, copied_d;
    logic [31:0] data_q,   data_d;

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        count_d  = count_q;
        copied_d = copied_q;
        data_d   = data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d    = source_address & 32'hFFFF_FFFC;
                    dst_d    = destination_address & 32'hFFFF_FFFC;
                    count_d  = word_count;
                    copied_d = 16'd0;
                    state_d  = (word_count == 16'd0) ? DONE : READ_REQ;
                end
            end
            READ_REQ:  state_d = READ_WAIT;
            READ_WAIT: begin
                if (m_port.m_rresponse) begin
                    data_d  = m_port.m_rdata;
                    state_d = WRITE_REQ;
                end
            end
            WRITE_REQ: state_d = WRITE_WAIT;
            WRITE_WAIT: begin
                if (m_port.m_wresponse) begin
                    copied_d = copied_q + 16'd1;
                    src_d    = src_q + 32'd4;
                    dst_d    = dst_q + 32'd4;
                    state_d  = (copied_q + 16'd1 == count_q) ? DONE : READ_REQ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            src_q    <= 32'd0;
            dst_q    <= 32'd0;
            count_q  <= 16'd0;
            copied_q <= 16'd0;
            data_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            count_q  <= count_d;
            copied_q <= copied_d;
            data_q   <= data_d;
        end
    end

    // Address is driven only while an access is pending so an idle port reads as zero.
    assign m_port.m_address  = (state_q == READ_REQ  || state_q == READ_WAIT)  ? src_q :
                               (state_q == WRITE_REQ || state_q == WRITE_WAIT) ? dst_q : 32'd0;
    assign m_port.m_rrequest = (state_q == READ_REQ);
    assign m_port.m_wrequest = (state_q == WRITE_REQ);
    assign m_port.m_wstrobe  = (state_q == WRITE_REQ) ? 4'hF : 4'h0;
    assign m_port.m_wdata    = data_q;

    assign busy         = (state_q == READ_REQ) || (state_q == READ_WAIT) ||
                          (state_q == WRITE_REQ) || (state_q == WRITE_WAIT);
    assign done         = (state_q == DONE);
    assign words_copied = copied_q;

endmodule

// File: tb/tb_rvx_memory_copy_engine.sv
// Directed bench for the copy engine against a behavioural memory with a
// programmable response delay; reads and writes are checked against a scoreboard.
module tb_rvx_memory_copy_engine;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wrExp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] srcAddr;
    logic [31:0] dstAddr;
    logic [15:0] wordCount;
    logic        busy;
    logic        done;
    logic [15:0] wordsCopied;

    int checks = 0;
    int errors = 0;
    int respDelay = 0;
    int rdReqCount = 0;
    int wrReqCount = 0;
    int doneCount = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] readQ [$];
    wrExp_t      writeQ [$];

    rvx_memory_copy_engine_if memIf ();

    rvx_memory_copy_engine dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .start               (start),
        .source_address      (srcAddr),
        .destination_address (dstAddr),
        .word_count          (wordCount),
        .busy                (busy),
        .done                (done),
        .words_copied        (wordsCopied),
        .m_port              (memIf)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, obs, expv);
        end
    endtask

    // Memory model: writes commit when requested, responses follow after respDelay extra cycles.
    logic        rdPend = 1'b0, wrPend = 1'b0;
    int          rdCnt = 0, wrCnt = 0;
    logic [31:0] rdA = 32'd0;
    always @(posedge clock) begin
        memIf.m_rresponse <= 1'b0;
        memIf.m_wresponse <= 1'b0;
        if (!reset_n) begin
            memIf.m_rdata <= 32'd0;
        end
        if (memIf.m_rrequest) begin
            rdPend = 1'b1;
            rdCnt  = respDelay;
            rdA    = memIf.m_address;
        end else if (rdPend) begin
            rdCnt = rdCnt - 1;
        end
        if (rdPend && rdCnt == 0) begin
            memIf.m_rresponse <= 1'b1;
            memIf.m_rdata     <= mem.exists(rdA) ? mem[rdA] : 32'hDEAD_BEEF;
            rdPend = 1'b0;
        end
        if (memIf.m_wrequest) begin
            mem[memIf.m_address] = memIf.m_wdata;
            wrPend = 1'b1;
            wrCnt  = respDelay;
        end else if (wrPend) begin
            wrCnt = wrCnt - 1;
        end
        if (wrPend && wrCnt == 0) begin
            memIf.m_wresponse <= 1'b1;
            wrPend = 1'b0;
        end
    end

    // Port monitor: scoreboard pops, single-cycle request pulses, address/data hold during waits.
    logic        inRead = 1'b0, inWrite = 1'b0;
    logic [31:0] holdRdAddr = 32'd0, holdWrAddr = 32'd0, holdWrData = 32'd0;
    always @(negedge clock) begin
        if (!reset_n) begin
            inRead  = 1'b0;
            inWrite = 1'b0;
        end else begin
            if (done) doneCount++;
            checkOutput("wstrobe_rule", {28'd0, memIf.m_wstrobe},
                        memIf.m_wrequest ? 32'hF : 32'h0);
            if (memIf.m_rrequest) begin
                rdReqCount++;
                checkOutput("read_single_pulse", {31'd0, inRead}, 32'd0);
                if (readQ.size() == 0) checkOutput("unexpected_read", memIf.m_address, 32'hFFFF_FFFF);
                else checkOutput("read_addr", memIf.m_address, readQ.pop_front());
                inRead     = 1'b1;
                holdRdAddr = memIf.m_address;
            end else if (inRead) begin
                checkOutput("read_wait_addr_stable", memIf.m_address, holdRdAddr);
                if (memIf.m_rresponse) inRead = 1'b0;
            end
            if (memIf.m_wrequest) begin
                wrReqCount++;
                checkOutput("write_single_pulse", {31'd0, inWrite}, 32'd0);
                if (writeQ.size() == 0) begin
                    checkOutput("unexpected_write", memIf.m_address, 32'hFFFF_FFFF);
                end else begin
                    wrExp_t e;
                    e = writeQ.pop_front();
                    checkOutput("write_addr", memIf.m_address, e.a);
                    checkOutput("write_data", memIf.m_wdata, e.d);
                end
                inWrite    = 1'b1;
                holdWrAddr = memIf.m_address;
                holdWrData = memIf.m_wdata;
            end else if (inWrite) begin
                checkOutput("write_wait_addr_stable", memIf.m_address, holdWrAddr);
                checkOutput("write_wait_data_stable", memIf.m_wdata, holdWrData);
                if (memIf.m_wresponse) inWrite = 1'b0;
            end
        end
    end

    task automatic pushExpected(input logic [31:0] src, input logic [31:0] dst, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            wrExp_t e;
            logic [31:0] a;
            a   = (src & 32'hFFFF_FFFC) + 32'(4 * i);
            e.a = (dst & 32'hFFFF_FFFC) + 32'(4 * i);
            e.d = mem[a];
            readQ.push_back(a);
            writeQ.push_back(e);
        end
    endtask

    // Starts a copy at a negedge and returns the number of edges until done is seen (-1 on timeout).
    task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst, input int cnt,
                                 input bit holdStart, output int lat);
        pushExpected(src, dst, cnt);
        srcAddr   = src;
        dstAddr   = dst;
        wordCount = 16'(cnt);
        start     = 1'b1;
        lat       = -1;
        @(posedge clock);
        for (int k = 1; k <= 500; k++) begin
            @(negedge clock);
            if (k == 1 && !holdStart) start = 1'b0;
            if (done) begin
                lat   = k;
                start = 1'b0;
                break;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int lat;
        int rdBase, wrBase, doneBase;
        reset_n   = 1'b0;
        start     = 1'b0;
        srcAddr   = 32'd0;
        dstAddr   = 32'd0;
        wordCount = 16'd0;
        for (int i = 0; i < 4; i++) begin
            mem[32'h100 + 32'(4 * i)] = 32'hA000_0000 + 32'(i);
            mem[32'h200 + 32'(4 * i)] = 32'h0;
            mem[32'h300 + 32'(4 * i)] = 32'h0;
            mem[32'h400 + 32'(4 * i)] = 32'h0;
            mem[32'h500 + 32'(4 * i)] = 32'h0;
        end

        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_rreq", {31'd0, memIf.m_rrequest}, 32'd0);
        checkOutput("reset_wreq", {31'd0, memIf.m_wrequest}, 32'd0);
        checkOutput("reset_wstrobe", {28'd0, memIf.m_wstrobe}, 32'd0);
        checkOutput("reset_addr", memIf.m_address, 32'd0);
        checkOutput("reset_words", {16'd0, wordsCopied}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        $display("[TB] four-word copy 0x100 -> 0x200");
        applyStimulus(32'h100, 32'h200, 4, 1'b0, lat);
        checkOutput("copy4_latency", lat, 32'd17);
        checkOutput("copy4_words", {16'd0, wordsCopied}, 32'd4);
        checkOutput("copy4_busy_in_done", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 4; i++)
            checkOutput("copy4_mem", mem[32'h200 + 32'(4 * i)], 32'hA000_0000 + 32'(i));
        @(negedge clock);
        checkOutput("copy4_done_pulse", {31'd0, done}, 32'd0);
        checkOutput("copy4_idle_busy", {31'd0, busy}, 32'd0);

        $display("[TB] zero-word copy");
        rdBase = rdReqCount;
        wrBase = wrReqCount;
        applyStimulus(32'h100, 32'h300, 0, 1'b0, lat);
        checkOutput("zero_latency", lat, 32'd1);
        checkOutput("zero_words", {16'd0, wordsCopied}, 32'd0);
        repeat (3) @(negedge clock);
        checkOutput("zero_no_reads", rdReqCount - rdBase, 32'd0);
        checkOutput("zero_no_writes", wrReqCount - wrBase, 32'd0);

        $display("[TB] unaligned addresses");
        applyStimulus(32'h103, 32'h202, 1, 1'b0, lat);
        checkOutput("unaligned_latency", lat, 32'd5);
        checkOutput("unaligned_mem", mem[32'h200], 32'hA000_0000);
        @(negedge clock);

        $display("[TB] slow responder");
        respDelay = 3;
        applyStimulus(32'h100, 32'h300, 4, 1'b0, lat);
        checkOutput("slow_latency", lat, 32'd41);
        for (int i = 0; i < 4; i++)
            checkOutput("slow_mem", mem[32'h300 + 32'(4 * i)], 32'hA000_0000 + 32'(i));
        respDelay = 0;
        @(negedge clock);

        $display("[TB] reset in the middle of a copy");
        readQ.push_back(32'h100);
        readQ.push_back(32'h104);
        begin
            wrExp_t e;
            e.a = 32'h400;
            e.d = 32'hA000_0000;
            writeQ.push_back(e);
        end
        srcAddr   = 32'h100;
        dstAddr   = 32'h400;
        wordCount = 16'd4;
        start     = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        wrBase  = wrReqCount;
        @(negedge clock);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        checkOutput("abort_rreq", {31'd0, memIf.m_rrequest}, 32'd0);
        checkOutput("abort_wreq", {31'd0, memIf.m_wrequest}, 32'd0);
        checkOutput("abort_wstrobe", {28'd0, memIf.m_wstrobe}, 32'd0);
        checkOutput("abort_addr", memIf.m_address, 32'd0);
        checkOutput("abort_words", {16'd0, wordsCopied}, 32'd0);
        checkOutput("abort_data_reg", memIf.m_wdata, 32'd0);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
        checkOutput("abort_no_more_writes", wrReqCount - wrBase, 32'd0);
        checkOutput("abort_mem_untouched", mem[32'h404], 32'd0);
        checkOutput("abort_rd_queue_empty", readQ.size(), 32'd0);
        checkOutput("abort_wr_queue_empty", writeQ.size(), 32'd0);
        applyStimulus(32'h100, 32'h400, 4, 1'b0, lat);
        checkOutput("after_abort_latency", lat, 32'd17);
        checkOutput("after_abort_mem", mem[32'h40C], 32'hA000_0003);
        @(negedge clock);

        $display("[TB] start held high through a copy");
        doneBase = doneCount;
        wrBase   = wrReqCount;
        applyStimulus(32'h100, 32'h500, 2, 1'b1, lat);
        checkOutput("held_latency", lat, 32'd9);
        @(negedge clock);
        checkOutput("held_idle_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clock);
        checkOutput("held_still_idle", {31'd0, busy}, 32'd0);
        checkOutput("held_one_done", doneCount - doneBase, 32'd1);
        checkOutput("held_two_writes", wrReqCount - wrBase, 32'd2);
        checkOutput("held_mem", mem[32'h504], 32'hA000_0001);

        checkOutput("final_rd_queue_empty", readQ.size(), 32'd0);
        checkOutput("final_wr_queue_empty", writeQ.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
